// File: rtl/user_lock_arbiter.sv
// Exclusive-lock arbiter for an 8-bit register shared by four user IDs.
// Round-robin lock grant, owner-only writes, explicit/forced/timeout release.
module user_lock_arbiter #(
  parameter logic [3:0]  ALLOW_MASK = 4'b1111,
  parameter logic [1:0]  PRIV_ID    = 2'h2,
  parameter int unsigned HOLD_MAX   = 64,
  parameter logic [7:0]  RST_VAL    = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  lock_req_i,
  input  logic [3:0]  lock_rel_i,
  input  logic [3:0]  wr_en_i,
  input  logic [31:0] wdata_i,
  input  logic        force_rel_i,
  input  logic [1:0]  force_usr_id_i,
  output logic [3:0]  lock_gnt_o,
  output logic [1:0]  owner_id_o,
  output logic        locked_o,
  output logic [7:0]  data_out_o,
  output logic        viol_o,
  output logic [1:0]  viol_id_o,
  output logic        timeout_o
);

  localparam int unsigned N_ID   = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;

  typedef enum logic {S_IDLE, S_OWNED} state_e;

  state_e              state_q, state_d;
  logic [N_ID-1:0]     gnt_q, gnt_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic                locked_q, locked_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                viol_q, viol_d;
  logic [ID_W-1:0]     viol_id_q, viol_id_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     rr_q, rr_d;

  logic [N_ID-1:0]     eligible;
  logic [N_ID-1:0]     blocked;
  logic                found;
  logic [ID_W-1:0]     pick;
  logic [ID_W-1:0]     idx;
  logic                frc_rel;
  logic                own_rel;
  logic                tmo_rel;
  logic                viol_found;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      locked_q  <= 1'b0;
      data_q    <= RST_VAL;
      viol_q    <= 1'b0;
      viol_id_q <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      data_q    <= data_d;
      viol_q    <= viol_d;
      viol_id_q <= viol_id_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
    end
  end

  // Next-state: arbitration, write gating, release and violation detection
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    locked_d   = locked_q;
    data_d     = data_q;
    viol_d     = 1'b0;
    viol_id_d  = viol_id_q;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    eligible   = lock_req_i & ALLOW_MASK;
    blocked    = wr_en_i;
    found      = 1'b0;
    pick       = '0;
    idx        = '0;
    frc_rel    = force_rel_i && (force_usr_id_i == PRIV_ID);
    own_rel    = lock_rel_i[owner_q];
    tmo_rel    = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);
    viol_found = 1'b0;

    // Round-robin search starting just after the last owner
    for (int k = 0; k < N_ID; k++) begin
      idx = rr_q + ID_W'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_OWNED;
          gnt_d    = N_ID'(1) << pick;
          owner_d  = pick;
          locked_d = 1'b1;
          cnt_d    = '0;
          rr_d     = pick + ID_W'(1);
        end
      end
      S_OWNED: begin
        blocked = wr_en_i & ~gnt_q;
        if (wr_en_i[owner_q]) begin
          data_d = wdata_i[{owner_q, 3'b000} +: DATA_W];
        end
        if (frc_rel || own_rel || tmo_rel) begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          locked_d  = 1'b0;
          timeout_d = tmo_rel && !frc_rel && !own_rel;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < N_ID; i++) begin
      if (!viol_found && blocked[i]) begin
        viol_found = 1'b1;
        viol_id_d  = ID_W'(i);
      end
    end
    viol_d = viol_found;
  end

  assign lock_gnt_o = gnt_q;
  assign owner_id_o = owner_q;
  assign locked_o   = locked_q;
  assign data_out_o = data_q;
  assign viol_o     = viol_q;
  assign viol_id_o  = viol_id_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_user_lock_arbiter.sv
// Directed bench for user_lock_arbiter: dut_a uses default parameters,
// dut_b uses HOLD_MAX=4 and ALLOW_MASK=4'b1011 for timeout and masking.
module tb_user_lock_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  lock_req;
  logic [3:0]  lock_rel;
  logic [3:0]  wr_en;
  logic [31:0] wdata;
  logic        force_rel;
  logic [1:0]  force_usr_id;

  logic [3:0]  gnt_a, gnt_b;
  logic [1:0]  owner_a, owner_b;
  logic        locked_a, locked_b;
  logic [7:0]  data_a, data_b;
  logic        viol_a, viol_b;
  logic [1:0]  vid_a, vid_b;
  logic        tmo_a, tmo_b;

  int checks;
  int failures;

  user_lock_arbiter dut_a (
    .clk(clk), .rst_n(rst_n),
    .lock_req_i(lock_req), .lock_rel_i(lock_rel), .wr_en_i(wr_en),
    .wdata_i(wdata), .force_rel_i(force_rel), .force_usr_id_i(force_usr_id),
    .lock_gnt_o(gnt_a), .owner_id_o(owner_a), .locked_o(locked_a),
    .data_out_o(data_a), .viol_o(viol_a), .viol_id_o(vid_a), .timeout_o(tmo_a)
  );

  user_lock_arbiter #(.ALLOW_MASK(4'b1011), .HOLD_MAX(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .lock_req_i(lock_req), .lock_rel_i(lock_rel), .wr_en_i(wr_en),
    .wdata_i(wdata), .force_rel_i(force_rel), .force_usr_id_i(force_usr_id),
    .lock_gnt_o(gnt_b), .owner_id_o(owner_b), .locked_o(locked_b),
    .data_out_o(data_b), .viol_o(viol_b), .viol_id_o(vid_b), .timeout_o(tmo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lock_req     = '0;
    lock_rel     = '0;
    wr_en        = '0;
    wdata        = '0;
    force_rel    = 1'b0;
    force_usr_id = '0;
  endtask

  int    order [5];
  int    id;
  logic [7:0] b;

  initial begin
    checks   = 0;
    failures = 0;
    order    = '{0, 1, 2, 3, 0};
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    check_eq("rst_gnt", 32'(gnt_a), 32'h0);
    check_eq("rst_owner", 32'(owner_a), 32'h0);
    check_eq("rst_locked", 32'(locked_a), 32'h0);
    check_eq("rst_data", 32'(data_a), 32'h00);
    check_eq("rst_viol", 32'(viol_a), 32'h0);
    check_eq("rst_timeout", 32'(tmo_a), 32'h0);

    // ID 2 acquires and writes
    lock_req = 4'b0100;
    step();
    check_eq("t1_gnt", 32'(gnt_a), 32'h4);
    check_eq("t1_owner", 32'(owner_a), 32'h2);
    check_eq("t1_locked", 32'(locked_a), 32'h1);
    check_eq("t6_masked_nogrant", 32'(locked_b), 32'h0);
    check_eq("t6_masked_noviol", 32'(viol_b), 32'h0);
    wr_en = 4'b0100;
    wdata = 32'h00A5_0000;
    step();
    check_eq("t1_data", 32'(data_a), 32'hA5);
    check_eq("t1_noviol", 32'(viol_a), 32'h0);

    // Non-owner write is blocked and reported
    wr_en = 4'b0010;
    wdata = 32'h0000_3C00;
    step();
    check_eq("t2_data_kept", 32'(data_a), 32'hA5);
    check_eq("t2_viol", 32'(viol_a), 32'h1);
    check_eq("t2_viol_id", 32'(vid_a), 32'h1);
    wr_en = '0;
    step();
    check_eq("t2_viol_pulse", 32'(viol_a), 32'h0);
    lock_req = '0;
    lock_rel = 4'b0100;
    step();
    lock_rel = '0;
    check_eq("t2_rel_locked", 32'(locked_a), 32'h0);
    check_eq("t2_rel_gnt", 32'(gnt_a), 32'h0);
    check_eq("t2_rel_owner", 32'(owner_a), 32'h2);

    // Round-robin order from reset with all IDs requesting
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    lock_req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      id = order[k];
      b  = 8'h10 + 8'(id);
      check_eq($sformatf("t3_gnt%0d", k), 32'(gnt_a), 32'(4'b0001 << id));
      check_eq($sformatf("t3_owner%0d", k), 32'(owner_a), 32'(id));
      wr_en    = 4'(4'b0001 << id);
      wdata    = {4{b}};
      lock_rel = 4'(4'b0001 << id);
      step();
      check_eq($sformatf("t3_idle%0d", k), 32'(locked_a), 32'h0);
      check_eq($sformatf("t3_data%0d", k), 32'(data_a), 32'(b));
      wr_en    = '0;
      lock_rel = '0;
      if (k == 4) lock_req = '0;
      step();
    end
    check_eq("t3_end_idle", 32'(locked_a), 32'h0);

    // Force release: only PRIV_ID honoured, same-cycle owner write commits
    lock_req = 4'b0001;
    step();
    lock_req = '0;
    check_eq("t5_gnt", 32'(gnt_a), 32'h1);
    force_rel    = 1'b1;
    force_usr_id = 2'd1;
    step();
    check_eq("t5_ignored", 32'(locked_a), 32'h1);
    force_usr_id = 2'd2;
    wr_en        = 4'b0001;
    wdata        = 32'h0000_007E;
    step();
    check_eq("t5_forced", 32'(locked_a), 32'h0);
    check_eq("t5_gnt_clr", 32'(gnt_a), 32'h0);
    check_eq("t5_no_timeout", 32'(tmo_a), 32'h0);
    check_eq("t5_data", 32'(data_a), 32'h7E);
    clear_inputs();

    // dut_b: masked ID never granted, hold timeout, async reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    lock_req = 4'b0100;
    step();
    step();
    step();
    check_eq("t6_never_gnt", 32'(gnt_b), 32'h0);
    check_eq("t6_never_viol", 32'(viol_b), 32'h0);
    lock_req = 4'b1000;
    step();
    lock_req = '0;
    check_eq("t4_gnt", 32'(gnt_b), 32'h8);
    for (int c = 1; c <= 3; c++) begin
      step();
      check_eq($sformatf("t4_held%0d", c), 32'(locked_b), 32'h1);
      check_eq($sformatf("t4_notmo%0d", c), 32'(tmo_b), 32'h0);
    end
    step();
    check_eq("t4_dropped", 32'(locked_b), 32'h0);
    check_eq("t4_timeout", 32'(tmo_b), 32'h1);
    check_eq("t4_owner_kept", 32'(owner_b), 32'h3);
    step();
    check_eq("t4_timeout_pulse", 32'(tmo_b), 32'h0);

    lock_req = 4'b1000;
    step();
    lock_req = '0;
    wr_en = 4'b1000;
    wdata = 32'h5A00_0000;
    step();
    wr_en = '0;
    check_eq("t6_data", 32'(data_b), 32'h5A);
    check_eq("t6_owned", 32'(locked_b), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_gnt", 32'(gnt_b), 32'h0);
    check_eq("t6_rst_locked", 32'(locked_b), 32'h0);
    check_eq("t6_rst_data", 32'(data_b), 32'h00);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
